// File: rtl/esm_pkg.sv
// Shared types and helpers for the ESM instruction-buffer control blocks.
package esm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } esm_seq_state_t;

    // Index width for a buffer of the given (power-of-two) depth.
    function automatic int esm_idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/esm_buffer_sequencer.sv
// Fill/drain sequencer driving the ESM InstructionBuffer address, write strobe and output handshake.
// Optional feature: define ESM_SEQ_REPLAY_EN to add the replay input (re-drain the stored block without a refill).
module esm_buffer_sequencer
    import esm_pkg::*;
#(
    parameter int Instruction_word_size = 16,
    parameter int bs                    = 16,
    localparam int IW                   = esm_idx_width(bs)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
`ifdef ESM_SEQ_REPLAY_EN
    input  logic                             replay,
`endif
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_last,
    input  logic [Instruction_word_size-1:0] Instr_in,
    output logic                             buf_we,
    output logic [IW-1:0]                    buf_index,
    output logic [Instruction_word_size-1:0] buf_wdata,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic [IW:0]                      blk_len,
    output logic                             busy
);

    esm_seq_state_t state_q, state_d;
    logic [IW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [IW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [IW:0]    blk_len_q, blk_len_d;
    logic           out_valid_q, out_valid_d;

    logic in_fire_s;
    logic out_fire_s;
    logic blk_end_s;
    logic out_last_s;
    logic replay_go_s;

`ifdef ESM_SEQ_REPLAY_EN
    assign replay_go_s = (state_q == IDLE) & replay & (blk_len_q != {(IW+1){1'b0}});
`else
    assign replay_go_s = 1'b0;
`endif

    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid_q & out_ready;
    assign blk_end_s  = in_fire_s & (in_last | (wr_ptr_q == IW'(bs - 1)));
    assign out_last_s = out_valid_q & ({1'b0, rd_ptr_q} == (blk_len_q - (IW+1)'(1)));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides any handshake in the same cycle
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (replay_go_s) begin
                        state_d = DRAIN;
                    end else if (blk_end_s) begin
                        state_d = DRAIN;
                    end else if (in_fire_s) begin
                        state_d = FILL;
                    end else begin
                        state_d = IDLE;
                    end
                end
                FILL: begin
                    if (blk_end_s) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = FILL;
                    end
                end
                DRAIN: begin
                    if (out_fire_s & out_last_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode; DRAIN addresses one slot ahead on a fire so the registered read has no bubbles
    always_comb begin
        in_ready  = 1'b0;
        buf_index = wr_ptr_q;
        case (state_q)
            IDLE: begin
                in_ready  = rst & ~replay_go_s;
                buf_index = wr_ptr_q;
            end
            FILL: begin
                in_ready  = rst;
                buf_index = wr_ptr_q;
            end
            DRAIN: begin
                in_ready = 1'b0;
                if (out_fire_s) begin
                    buf_index = rd_ptr_q + IW'(1);
                end else begin
                    buf_index = rd_ptr_q;
                end
            end
            default: begin
                in_ready  = 1'b0;
                buf_index = wr_ptr_q;
            end
        endcase
    end

    assign buf_we    = in_fire_s;
    assign buf_wdata = Instr_in;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_s;
    assign blk_len   = blk_len_q;
    assign busy      = (state_q != IDLE);

    // Pointer, length and output-valid next values
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        blk_len_d   = blk_len_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            wr_ptr_d    = {IW{1'b0}};
            rd_ptr_d    = {IW{1'b0}};
            blk_len_d   = {(IW+1){1'b0}};
            out_valid_d = 1'b0;
        end else if (replay_go_s) begin
            rd_ptr_d    = {IW{1'b0}};
            out_valid_d = 1'b0;
        end else if (blk_end_s) begin
            blk_len_d   = {1'b0, wr_ptr_q} + (IW+1)'(1);
            wr_ptr_d    = {IW{1'b0}};
            rd_ptr_d    = {IW{1'b0}};
            out_valid_d = 1'b0;
        end else if (in_fire_s) begin
            wr_ptr_d = wr_ptr_q + IW'(1);
        end else if (state_q == DRAIN) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
            end else if (out_fire_s & out_last_s) begin
                out_valid_d = 1'b0;
                rd_ptr_d    = {IW{1'b0}};
            end else if (out_fire_s) begin
                rd_ptr_d = rd_ptr_q + IW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= {IW{1'b0}};
            rd_ptr_q    <= {IW{1'b0}};
            blk_len_q   <= {(IW+1){1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            blk_len_q   <= blk_len_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_esm_buffer_sequencer.sv
// Self-checking bench: a behavioural buffer plus a queue of expected words checks fill addressing and drain order.
module tb_esm_buffer_sequencer;

    localparam int W  = 16;
    localparam int BS = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          replay = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [W-1:0]  Instr_in = '0;
    logic          buf_we;
    logic [IW-1:0] buf_index;
    logic [W-1:0]  buf_wdata;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic [IW:0]   blk_len;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mem [BS];
    logic [W-1:0] instr_out;
    logic [W-1:0] exp_q [$];

    esm_buffer_sequencer #(.Instruction_word_size(W), .bs(BS)) dut (
        .clk(clk), .rst(rst), .flush(flush),
`ifdef ESM_SEQ_REPLAY_EN
        .replay(replay),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .Instr_in(Instr_in),
        .buf_we(buf_we), .buf_index(buf_index), .buf_wdata(buf_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .blk_len(blk_len), .busy(busy)
    );

    always #5 clk = ~clk;

    // InstructionBuffer stand-in: synchronous write, registered read
    always @(posedge clk) begin
        if (buf_we) mem[buf_index] <= buf_wdata;
        instr_out <= mem[buf_index];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Feed n words; base<0 means random data. Checks each write beat and the DRAIN entry cycle.
    task automatic fill(input int n, input bit use_last, input int base);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            Instr_in = (base < 0) ? W'($urandom) : W'(base + i);
            in_last  = use_last && (i == n - 1);
            exp_q.push_back(Instr_in);
            #1;
            chk("fill_in_ready", in_ready, 1);
            chk("fill_buf_we", buf_we, 1);
            chk("fill_buf_index", buf_index, i);
            chk("fill_buf_wdata", buf_wdata, exp_q[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        chk("entry_busy", busy, 1);
        chk("entry_out_valid", out_valid, 0);
        chk("entry_in_ready", in_ready, 0);
        chk("entry_blk_len", blk_len, n);
        chk("entry_buf_index", buf_index, 0);
    endtask

    // Drain n words; mode 0 ready=1, 1 pattern 1,0,0, 2 random. flush_at>=0 aborts on that slot's fire.
    task automatic drain(input int n, input int mode, input int flush_at);
        int  got = 0;
        int  vcnt = 0;
        bit  done = 0;
        bit  flushed = 0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((vcnt % 3) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            flush = (flush_at >= 0) && out_valid && (got == flush_at);
            if (flush) out_ready = 1'b1;
            #1;
            if (out_valid) begin
                vcnt++;
                chk("drain_out_last", out_last, (got == n - 1));
                if (out_ready) begin
                    chk("drain_data", instr_out, exp_q[got]);
                    if (got != n - 1) chk("drain_lookahead_idx", buf_index, (got + 1) % BS);
                    got++;
                    if (got == n || flush) done = 1;
                    flushed = flush;
                end else begin
                    chk("drain_stall_idx", buf_index, got);
                end
            end
        end
        chk("drain_completed", done, 1);
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("drain_end_busy", busy, 0);
        chk("drain_end_out_valid", out_valid, 0);
        chk("drain_end_blk_len", blk_len, flushed ? 0 : n);
    endtask

    initial begin
        int n;
        bit ul;

        // Reset held two cycles with a valid upstream word
        rst = 1'b0;
        in_valid = 1'b1;
        Instr_in = 16'h1234;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rst_in_ready", in_ready, 0);
            chk("rst_buf_we", buf_we, 0);
        end
        chk("rst_out_valid", out_valid, 0);
        chk("rst_blk_len", blk_len, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;

        // Four fixed words, continuous ready
        fill(4, 1'b1, 32'hA000);
        drain(4, 0, -1);

        // Full-depth blocks: implicit end, then in_last coinciding with the last slot
        fill(16, 1'b0, -1);
        drain(16, 0, -1);
        fill(16, 1'b1, -1);
        drain(16, 2, -1);

        // Stalling consumer
        fill(6, 1'b1, -1);
        drain(6, 1, -1);

        // Flush on the fire of slot 2
        fill(5, 1'b1, -1);
        drain(5, 0, 2);

        // Single-word block ends in IDLE on its first beat
        fill(1, 1'b1, -1);
        drain(1, 1, -1);

        // Random blocks and random backpressure
        for (int k = 0; k < 8; k++) begin
            n  = $urandom_range(1, BS);
            ul = (n < BS) ? 1'b1 : 1'($urandom_range(0, 1));
            fill(n, ul, -1);
            drain(n, 2, -1);
        end

`ifdef ESM_SEQ_REPLAY_EN
        fill(3, 1'b1, -1);
        drain(3, 0, -1);
        @(negedge clk);
        replay   = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("replay_in_ready", in_ready, 0);
        chk("replay_buf_we", buf_we, 0);
        @(negedge clk);
        replay   = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("replay_busy", busy, 1);
        chk("replay_out_valid", out_valid, 0);
        drain(3, 2, -1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush  = 1'b0;
        replay = 1'b1;
        #1;
        chk("replay_empty_len", blk_len, 0);
        @(negedge clk);
        replay = 1'b0;
        #1;
        chk("replay_empty_busy", busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
